softmax_exp_ctrl: RTL
=====================

Name: softmax_exp_ctrl

Overview:
- Sequencer for the softmax exp range-reduction datapath (x*log2e split into integer j / fraction m, fixed DP_LAT-cycle pipeline, no stall input).
- Buffers one input vector and finds its maximum on the way in, then streams x-max into the datapath with the configured x_shift.
- Collects (m, j) results in order into a credit-protected output FIFO with valid/ready handshake. Sits between the logit source and the exp/normalise stages.

Parameters:
- MAX_LEN, 64, max vector length held in the internal sample buffer (power of 2).
- DP_LAT, 3, datapath latency, dp_x/dp_x_shift presented to dp_m/dp_j valid, in cycles.
- FIFO_DEPTH, 8, output result FIFO depth; must be >= DP_LAT+1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-high reset (1 = reset), despite the suffix.
- cfg_shift  in  8  signed x_shift, sampled on the first accepted sample of each vector.
- in_valid  in  1  input sample valid.
- in_ready  out  1  high only in IDLE/LOAD.
- in_data  in  16  signed logit.
- in_last  in  1  marks final sample of the vector.
- dp_x  out  16  signed (x - max) to datapath.
- dp_x_shift  out  8  latched cfg_shift to datapath.
- dp_m  in  32  datapath m result.
- dp_j  in  5  datapath j result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_m  out  32  m of the head result.
- out_j  out  5  j of the head result.
- out_last  out  1  head result is the vector's last.
- busy  out  1  high in every state except IDLE.
- ovf  out  1  sticky; vector truncated at MAX_LEN. Cleared on next vector start.

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1. dp_x=0, dp_x_shift=0, out_valid=0, out_m=0, out_j=0, out_last=0, busy=0, ovf=0. Also cleared: FIFO, count, max, in-flight valid shift register, state=IDLE.
- FSM states: IDLE, LOAD, ISSUE, DRAIN.
- IDLE:
  - in_valid&in_ready stores in_data at addr 0, sets max=in_data, latches cfg_shift, clears ovf.
  - Goes to ISSUE if in_last, else LOAD.
- LOAD:
  - Each handshake writes buf[cnt] and sets max=max(max,in_data), signed compare.
  - cnt increments.
  - On in_last, go to ISSUE with len=cnt+1.
  - If the accepted sample fills MAX_LEN without in_last: treat it as last, set ovf=1, go to ISSUE. Later samples wait for the next vector.
- ISSUE:
  - Issue sample k when fifo_count + inflight < FIFO_DEPTH.
  - On issue, dp_x = sat16(buf[k] - max): 17-bit signed subtract, saturate to -32768 if below. The result is always <= 0.
  - A DP_LAT-deep valid/last shift register tracks in-flight samples; inflight = its population count.
  - After the sample at index len-1 is issued, go to DRAIN.
- DRAIN: when inflight==0, FIFO empty and no push pending, go to IDLE.
- Result push: when the valid shift register tail is 1, push {dp_m, dp_j, last} into the FIFO that cycle. The credit rule guarantees no overflow; a push into a full FIFO is a design error and is asserted in simulation.
- FIFO:
  - out_valid = !empty. Pop on out_valid&out_ready.
  - Push and pop in the same cycle leaves the count unchanged.
  - Outputs are registered FIFO head, in-order.
- Throughput:
  - With out_ready held 1, one issue per cycle and one result per cycle.
  - First result appears DP_LAT+1 cycles after the first issue (the extra cycle is the FIFO write).
- dp_x holds its last value when not issuing. dp_x_shift is constant for the whole vector.
- Reset mid-operation: everything returns to reset values next cycle. Datapath outputs already in flight are discarded because the valid shift register is cleared.
- Single-sample vector (in_last on the first sample): len=1, dp_x=0.

Test Plan:
- Vector [100,-20,300,5] with last on 5, cfg_shift=-3, out_ready=1 -> dp_x sequence -200,-320,0,-295; dp_x_shift=-3; 4 results in order, out_last only on the 4th; back to IDLE, busy=0.
- Vector [32767,-32768] -> dp_x 0 then saturated -32768 (raw -65535); ovf=0.
- 65 samples with no in_last -> ovf=1 after sample 64; exactly 64 results, last flagged; sample 65 accepted as first of the next vector, ovf cleared then.
- out_ready=0 for 20 cycles during an 8-sample vector -> at most FIFO_DEPTH results buffered; issue stalls; no loss or reorder after out_ready=1; total 8 results.
- Single sample 1234, in_last=1 -> one issue with dp_x=0; one result with out_last=1, DP_LAT+1 cycles after issue.
- rst_n=1 for one cycle while 3 samples are in flight -> out_valid=0, FIFO empty, busy=0; the next vector produces only its own results.

Source files
------------

// File: rtl/softmax_exp_ctrl.sv
// softmax_exp_ctrl
//   Sequencer for the softmax exp range-reduction datapath. Buffers one input
//   vector while tracking its maximum, then streams sat16(x - max) plus the
//   vector's x_shift into a fixed-latency datapath. Results come back into a
//   credit-protected FIFO, drained in order through a valid/ready port.
//
// Ports
//   clk, rst_n          clock; synchronous reset, active HIGH despite the name
//   cfg_shift           x_shift, latched on the first sample of each vector
//   in_valid/in_ready   logit input handshake, in_data signed, in_last ends vector
//   dp_x, dp_x_shift    operands to the datapath
//   dp_m, dp_j          datapath results, valid DP_LAT cycles after dp_x
//   out_valid/out_ready result handshake; out_m/out_j/out_last = FIFO head
//   busy                high in every state except IDLE
//   ovf                 sticky: last vector was truncated at MAX_LEN
module softmax_exp_ctrl #(
    parameter int MAX_LEN    = 64,
    parameter int DP_LAT     = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cfg_shift,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic [15:0] dp_x,
    output logic [7:0]  dp_x_shift,
    input  logic [31:0] dp_m,
    input  logic [4:0]  dp_j,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_m,
    output logic [4:0]  out_j,
    output logic        out_last,
    output logic        busy,
    output logic        ovf
);
    localparam int AW  = $clog2(MAX_LEN);
    localparam int CW  = AW + 1;
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = $clog2(FIFO_DEPTH + DP_LAT + 2) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DRAIN} state_t;
    state_t state;

    logic [15:0]        sbuf [MAX_LEN];
    logic signed [15:0] max_q;
    logic [CW-1:0]      cnt, len, idx;
    logic [DP_LAT:0]    vld_pipe, lst_pipe;

    logic [37:0]        fmem [FIFO_DEPTH];
    logic [FAW-1:0]     wr_ptr, rd_ptr, rd_nxt;
    logic [FCW-1:0]     f_cnt, f_cnt_nxt;
    logic [37:0]        push_data, head_nxt;

    logic               accept, issue, last_issue, push, pop;
    logic [PW-1:0]      inflight, credit_used;
    logic [15:0]        rd_val, x_sat;
    logic [16:0]        diff;
    logic [AW-1:0]      wr_addr;

    function automatic logic [FAW-1:0] ptr_inc(input logic [FAW-1:0] p);
        return (p == FAW'(FIFO_DEPTH - 1)) ? '0 : p + FAW'(1);
    endfunction

    assign accept     = in_valid && in_ready;
    assign wr_addr    = (state == IDLE) ? '0 : cnt[AW-1:0];
    assign last_issue = (idx == len - CW'(1));

    // x - max is never positive, so only the negative rail needs clamping:
    // bits [16:15] == 2'b10 means the 17-bit result is below -32768.
    assign rd_val = sbuf[idx[AW-1:0]];
    assign diff   = {rd_val[15], rd_val} - {max_q[15], max_q};
    assign x_sat  = (diff[16:15] == 2'b10) ? 16'h8000 : diff[15:0];

    // Every in-flight sample owns a FIFO slot, so pushes can never overflow.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= DP_LAT; i++) inflight = inflight + PW'(vld_pipe[i]);
    end
    assign credit_used = inflight + PW'(f_cnt);
    assign issue       = (state == ISSUE) && (credit_used < PW'(FIFO_DEPTH));

    // Tail of the valid pipe lines up with dp_m/dp_j for that sample.
    assign push      = vld_pipe[DP_LAT];
    assign push_data = {dp_m, dp_j, lst_pipe[DP_LAT]};
    assign pop       = out_valid && out_ready;
    assign rd_nxt    = pop ? ptr_inc(rd_ptr) : rd_ptr;
    assign f_cnt_nxt = f_cnt + FCW'(push) - FCW'(pop);
    // When the FIFO is (or becomes) empty the pushed entry bypasses to the head.
    assign head_nxt  = (f_cnt == FCW'(pop)) ? push_data : fmem[rd_nxt];

    always_ff @(posedge clk) begin
        if (push)   fmem[wr_ptr]  <= push_data;
        if (accept) sbuf[wr_addr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
            cnt        <= '0;
            len        <= '0;
            idx        <= '0;
            max_q      <= '0;
            dp_x       <= '0;
            dp_x_shift <= '0;
            vld_pipe   <= '0;
            lst_pipe   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            f_cnt      <= '0;
            out_valid  <= 1'b0;
            out_m      <= '0;
            out_j      <= '0;
            out_last   <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[DP_LAT-1:0], issue};
            lst_pipe <= {lst_pipe[DP_LAT-1:0], issue && last_issue};

            if (push) wr_ptr <= ptr_inc(wr_ptr);
            rd_ptr    <= rd_nxt;
            f_cnt     <= f_cnt_nxt;
            out_valid <= (f_cnt_nxt != '0);
            {out_m, out_j, out_last} <= head_nxt;

            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        max_q      <= in_data;
                        dp_x_shift <= cfg_shift;
                        ovf        <= 1'b0;
                        cnt        <= CW'(1);
                        idx        <= '0;
                        busy       <= 1'b1;
                        if (in_last) begin
                            len      <= CW'(1);
                            in_ready <= 1'b0;
                            state    <= ISSUE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if ($signed(in_data) > max_q) max_q <= in_data;
                        cnt <= cnt + CW'(1);
                        // A full buffer closes the vector; the rest waits.
                        if (in_last || cnt == CW'(MAX_LEN - 1)) begin
                            len      <= cnt + CW'(1);
                            ovf      <= !in_last;
                            in_ready <= 1'b0;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        dp_x <= x_sat;
                        idx  <= idx + CW'(1);
                        if (last_issue) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (vld_pipe == '0 && f_cnt == '0) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n && push && !pop) assert (f_cnt != FCW'(FIFO_DEPTH));
    end
endmodule
